// File: rtl/dual_fetch_stage.sv
// Dual-lane fetch stage: owns the fetch PC, issues a (PC, PC+4) bundle and registers it into both ID lanes.
// Optional alignment checking is built only when IF_ADDR_CHECK_EN is defined.
module dual_fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  int_lines,
  input  logic        branch_1,
  input  logic        branch_2,
  input  logic [31:0] branch_target,
  input  logic        delay,
  input  logic        inst_delay_fetch,
  input  logic        IADEE,
  input  logic        IADFE,
  input  logic [31:0] exc_PC,
  input  logic [31:0] MEM_inst_1,
  input  logic [31:0] MEM_inst_2,
  output logic [31:0] PC_1,
  output logic [31:0] PC_2,
  output logic [31:0] inst_1,
  output logic [31:0] inst_2,
  output logic [31:0] ID_PC_1,
  output logic [31:0] ID_PC_2,
  output logic [1:0]  IC_IF_1,
  output logic [1:0]  IC_IF_2
);

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q  [2];
  logic [31:0] inst_d  [2];
  logic [31:0] id_pc_q [2];
  logic [31:0] id_pc_d [2];
  logic [1:0]  ic_if_q [2];
  logic [1:0]  ic_if_d [2];

  logic [31:0] lane_pc  [2];
  logic [31:0] mem_inst [2];
  logic [1:0]  lane_fault;
  logic [1:0]  lane_intr;
  logic [1:0]  lane_keep;
  logic        exc_redirect;
  logic        stall;

  assign lane_pc[0]  = pc_q;
  assign lane_pc[1]  = pc_q + 32'd4;
  assign mem_inst[0] = MEM_inst_1;
  assign mem_inst[1] = MEM_inst_2;

  assign exc_redirect = IADEE | IADFE;
  assign stall        = delay | inst_delay_fetch;

  // Interrupts are tagged on lane 1 only; branch_1 kills both lanes,
  // branch_2 kills lane 2 because lane 1 is its delay slot.
  assign lane_intr = {1'b0, |int_lines};
  assign lane_keep = {~(branch_1 | branch_2), ~branch_1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane_fault
`ifdef IF_ADDR_CHECK_EN
      assign lane_fault[gi] = |lane_pc[gi][1:0];
`else
      assign lane_fault[gi] = 1'b0;
`endif
    end
  endgenerate

  always_comb begin
    pc_d = pc_q;
    for (int i = 0; i < 2; i++) begin
      inst_d[i]  = inst_q[i];
      id_pc_d[i] = id_pc_q[i];
      ic_if_d[i] = ic_if_q[i];
    end

    if (exc_redirect) begin
      // Exception entry/return overrides a stall.
      pc_d = exc_PC;
      for (int i = 0; i < 2; i++) begin
        inst_d[i]  = 32'd0;
        ic_if_d[i] = 2'b00;
      end
    end else if (!stall) begin
      for (int i = 0; i < 2; i++) begin
        id_pc_d[i] = lane_pc[i];
        if (lane_keep[i]) begin
          ic_if_d[i] = {lane_intr[i], lane_fault[i]};
          inst_d[i]  = lane_fault[i] ? 32'd0 : mem_inst[i];
        end else begin
          ic_if_d[i] = 2'b00;
          inst_d[i]  = 32'd0;
        end
      end
      if (branch_1 || branch_2) begin
        pc_d = branch_target;
      end else begin
        pc_d = pc_q + 32'd8;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 2; i++) begin
        inst_q[i]  <= 32'd0;
        id_pc_q[i] <= 32'd0;
        ic_if_q[i] <= 2'b00;
      end
    end else begin
      pc_q <= pc_d;
      for (int i = 0; i < 2; i++) begin
        inst_q[i]  <= inst_d[i];
        id_pc_q[i] <= id_pc_d[i];
        ic_if_q[i] <= ic_if_d[i];
      end
    end
  end

  assign PC_1    = pc_q;
  assign PC_2    = pc_q + 32'd4;
  assign inst_1  = inst_q[0];
  assign inst_2  = inst_q[1];
  assign ID_PC_1 = id_pc_q[0];
  assign ID_PC_2 = id_pc_q[1];
  assign IC_IF_1 = ic_if_q[0];
  assign IC_IF_2 = ic_if_q[1];

endmodule

// File: tb/tb_dual_fetch_stage.sv
// Bench for dual_fetch_stage: directed walk through the fetch scenarios, then randomized
// inputs checked edge by edge against a bundle-level reference model.
module tb_dual_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  int_lines;
  logic        branch_1, branch_2;
  logic [31:0] branch_target;
  logic        delay, inst_delay_fetch;
  logic        IADEE, IADFE;
  logic [31:0] exc_PC;
  logic [31:0] MEM_inst_1, MEM_inst_2;
  logic [31:0] PC_1, PC_2, inst_1, inst_2, ID_PC_1, ID_PC_2;
  logic [1:0]  IC_IF_1, IC_IF_2;

  dual_fetch_stage dut (
    .clk(clk), .reset(reset), .int_lines(int_lines),
    .branch_1(branch_1), .branch_2(branch_2), .branch_target(branch_target),
    .delay(delay), .inst_delay_fetch(inst_delay_fetch),
    .IADEE(IADEE), .IADFE(IADFE), .exc_PC(exc_PC),
    .MEM_inst_1(MEM_inst_1), .MEM_inst_2(MEM_inst_2),
    .PC_1(PC_1), .PC_2(PC_2), .inst_1(inst_1), .inst_2(inst_2),
    .ID_PC_1(ID_PC_1), .ID_PC_2(ID_PC_2), .IC_IF_1(IC_IF_1), .IC_IF_2(IC_IF_2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: fetch address plus what each ID lane currently holds.
  logic [31:0] m_pc;
  logic [31:0] m_inst [2];
  logic [31:0] m_idpc [2];
  logic [1:0]  m_icif [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  function automatic logic misaligned(input logic [31:0] a);
`ifdef IF_ADDR_CHECK_EN
    return (a % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_pc = 32'hBFC0_0000;
    for (int i = 0; i < 2; i++) begin
      m_inst[i] = 0; m_idpc[i] = 0; m_icif[i] = 0;
    end
  endtask

  // Applies the next-PC priority rules to the inputs currently driven.
  task automatic model_edge();
    logic fault;
    if (IADEE || IADFE) begin
      m_pc = exc_PC;
      for (int i = 0; i < 2; i++) begin m_inst[i] = 0; m_icif[i] = 0; end
    end else if (delay || inst_delay_fetch) begin
      // everything holds
    end else begin
      fault     = misaligned(m_pc);
      m_idpc[0] = m_pc;
      m_idpc[1] = m_pc + 32'd4;
      if (branch_1) begin
        for (int i = 0; i < 2; i++) begin m_inst[i] = 0; m_icif[i] = 0; end
        m_pc = branch_target;
      end else begin
        m_icif[0] = {(int_lines != 0), fault};
        m_inst[0] = fault ? 32'd0 : MEM_inst_1;
        if (branch_2) begin
          m_inst[1] = 0; m_icif[1] = 0;
          m_pc = branch_target;
        end else begin
          m_icif[1] = {1'b0, fault};
          m_inst[1] = fault ? 32'd0 : MEM_inst_2;
          m_pc = m_pc + 32'd8;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".PC_1"},    PC_1,    m_pc);
    check({tag, ".PC_2"},    PC_2,    m_pc + 32'd4);
    check({tag, ".inst_1"},  inst_1,  m_inst[0]);
    check({tag, ".inst_2"},  inst_2,  m_inst[1]);
    check({tag, ".ID_PC_1"}, ID_PC_1, m_idpc[0]);
    check({tag, ".ID_PC_2"}, ID_PC_2, m_idpc[1]);
    check({tag, ".IC_IF_1"}, {30'd0, IC_IF_1}, {30'd0, m_icif[0]});
    check({tag, ".IC_IF_2"}, {30'd0, IC_IF_2}, {30'd0, m_icif[1]});
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    int_lines = 0; branch_1 = 0; branch_2 = 0; branch_target = 0;
    delay = 0; inst_delay_fetch = 0; IADEE = 0; IADFE = 0; exc_PC = 0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    MEM_inst_1 = 32'h2401_0001;
    MEM_inst_2 = 32'h2402_0002;
    model_reset();
    #12;
    check_all("reset");

    @(negedge clk);
    reset = 1'b1;
    step("first");
    check("tp.inst_1", inst_1, 32'h2401_0001);
    check("tp.ID_PC_1", ID_PC_1, 32'hBFC0_0000);
    check("tp.ID_PC_2", ID_PC_2, 32'hBFC0_0004);
    check("tp.PC_1", PC_1, 32'hBFC0_0008);

    delay = 1'b1;
    MEM_inst_1 = 32'hDEAD_0001;
    for (int k = 0; k < 3; k++) begin
      step("stall");
      check("tp.stall_PC_1", PC_1, 32'hBFC0_0008);
    end
    delay = 1'b0;
    step("resume");
    check("tp.resume_PC_1", PC_1, 32'hBFC0_0010);

    branch_1 = 1'b1; branch_target = 32'hBFC0_0100;
    step("br1");
    check("tp.br1_PC_1", PC_1, 32'hBFC0_0100);
    check("tp.br1_inst_1", inst_1, 32'd0);
    check("tp.br1_inst_2", inst_2, 32'd0);
    branch_1 = 1'b0;

    branch_2 = 1'b1; branch_target = 32'hBFC0_0200; MEM_inst_1 = 32'h1111_1111;
    step("br2");
    check("tp.br2_inst_1", inst_1, 32'h1111_1111);
    check("tp.br2_inst_2", inst_2, 32'd0);
    check("tp.br2_PC_1", PC_1, 32'hBFC0_0200);
    branch_2 = 1'b0;

    branch_1 = 1'b1; delay = 1'b1; branch_target = 32'h0000_1000;
    step("br_stall");
    check("tp.br_stall_PC_1", PC_1, 32'hBFC0_0200);
    branch_1 = 1'b0;

    IADEE = 1'b1; exc_PC = 32'hBFC0_0380;
    step("exc");
    check("tp.exc_PC_1", PC_1, 32'hBFC0_0380);
    check("tp.exc_inst_1", inst_1, 32'd0);
    check("tp.exc_inst_2", inst_2, 32'd0);
    IADEE = 1'b0; delay = 1'b0;

    branch_1 = 1'b1; branch_target = 32'hBFC0_0102;
    step("unaligned_br");
    branch_1 = 1'b0; int_lines = 6'b000100; MEM_inst_1 = 32'h2222_2222;
    step("unaligned_fetch");
`ifdef IF_ADDR_CHECK_EN
    check("tp.addr_IC_IF_1", {30'd0, IC_IF_1}, 32'd3);
    check("tp.addr_inst_1", inst_1, 32'd0);
`else
    check("tp.addr_IC_IF_1", {30'd0, IC_IF_1}, 32'd2);
    check("tp.addr_inst_1", inst_1, 32'h2222_2222);
`endif
    int_lines = 0;

    // Reset asserted mid-redirect takes effect without a clock edge.
    branch_1 = 1'b1; branch_target = 32'h1234_5678;
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();

    for (int n = 0; n < 2000; n++) begin
      int_lines        = ($urandom_range(1) != 0) ? 6'($urandom) : 6'd0;
      delay            = ($urandom_range(99) < 20);
      inst_delay_fetch = ($urandom_range(99) < 10);
      branch_1         = ($urandom_range(99) < 15);
      branch_2         = ($urandom_range(99) < 15);
      IADEE            = ($urandom_range(99) < 4);
      IADFE            = ($urandom_range(99) < 4);
      branch_target    = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(3) == 0) branch_target = branch_target | 32'($urandom_range(3));
      exc_PC           = $urandom & 32'hFFFF_FFFC;
      MEM_inst_1       = $urandom;
      MEM_inst_2       = $urandom;
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dual_fetch_stage.md
# dual_fetch_stage

Dual-lane instruction fetch stage of the two-way superscalar MIPS core; it merges the lane-1 and lane-2 fetch functions into one block. It owns the fetch PC and issues a two-instruction bundle (PC, PC+4) per advance. It registers the returned instruction pair plus PCs and fetch exception codes into the two ID lanes. It redirects on taken branches/jumps resolved in ID and on exception entry/return.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- int  in  6  pending hardware interrupt lines
- branch_1  in  1  lane-1 ID: taken branch/jump (J_1 included)
- branch_2  in  1  lane-2 ID: taken branch/jump
- branch_target  in  32  redirect target from the asserting ID lane
- delay  in  1  ID hazard stall; hold all state
- inst_delay_fetch  in  1  instruction memory not ready; hold all state
- IADEE  in  1  exception entry: redirect to exc_PC, squash
- IADFE  in  1  exception return (ERET): redirect to exc_PC, squash
- exc_PC  in  32  redirect address for IADEE/IADFE
- MEM_inst_1, MEM_inst_2  in  32 each  fetched words for PC, PC+4
- PC_1, PC_2  out  32 each  current fetch addresses (PC_2 = PC_1+4)
- inst_1, inst_2  out  32 each  instructions to ID lanes
- ID_PC_1, ID_PC_2  out  32 each  PCs of inst_1/inst_2
- IC_IF_1, IC_IF_2  out  2 each  fetch exception code: [0] address error, [1] interrupt pending

## Operation
- Internal PC register; PC_1 = PC, PC_2 = PC+4 (combinational, mod 2^32 wrap).
- Next-PC priority per edge:
  1. IADEE or IADFE
  2. stall (delay | inst_delay_fetch)
  3. branch_1
  4. branch_2
  5. sequential PC+8
- Exception/ERET: PC <= exc_PC; inst_1/inst_2 <= 0 (NOP); IC_IF_x <= 0. Applies even during a stall.
- Stall: PC and all ID outputs hold.
- branch_1: the delay slot is lane 2 of the bundle already in ID. PC <= branch_target; the bundle being fetched is squashed (both inst <= 0).
- branch_2: the delay slot is lane 1 of the bundle being fetched. Deliver inst_1 = MEM_inst_1 normally; inst_2 <= 0 with IC_IF_2 <= 0. PC <= branch_target.
- branch_1 and branch_2 together: branch_1 wins.
- Sequential: inst_x <= MEM_inst_x; ID_PC_1 <= PC; ID_PC_2 <= PC+4; PC <= PC+8.
- IC_IF_x[1] = |int when the bundle is captured, lane 1 only; IC_IF_2[1] = 0.
- IC_IF_x[0]: see Configuration.
- A lane with IC_IF_x[0]=1 delivers inst_x = 0.

## Timing
- Reset (async, reset=0) sets:
  - PC = 32'hBFC0_0000
  - inst_1/2 = 0
  - ID_PC_1/2 = 0
  - IC_IF_1/2 = 0
- Release of reset is synchronous to clk.
- One-cycle latency: the bundle at PC is visible on ID outputs the edge after MEM_inst is sampled.
- PC_1/PC_2 change only at rising edges.
- Redirects take effect the following edge: the first target bundle reaches ID two edges after branch assertion.
- Stall inputs are sampled at the edge; a stall asserted in the same cycle as a branch discards the branch. ID re-asserts the branch after the stall.
- Reset mid-stall or mid-redirect overrides everything immediately.

## Configuration
- IF_ADDR_CHECK_EN defined: IC_IF_x[0] = (PC_x[1:0] != 0), and the faulting lane is NOPed.
- IF_ADDR_CHECK_EN undefined: IC_IF_x[0] is constant 0 and no alignment check logic is built.

## Test plan
- Reset then release, MEM_inst_1=0x24010001, MEM_inst_2=0x24020002 -> after one edge:
  - inst_1=0x24010001, ID_PC_1=0xBFC00000
  - ID_PC_2=0xBFC00004
  - PC_1=0xBFC00008
- delay=1 for 3 cycles at PC=0xBFC00008 -> PC and all ID outputs unchanged; advance resumes when delay=0.
- branch_1=1, branch_target=0xBFC00100 -> next edge:
  - PC_1=0xBFC00100
  - inst_1=inst_2=0
- branch_2=1, target 0xBFC00200, MEM_inst_1=0x11111111 -> next edge:
  - inst_1=0x11111111
  - inst_2=0
  - PC_1=0xBFC00200
- IADEE=1 with delay=1, exc_PC=0xBFC00380 -> PC_1=0xBFC00380, both inst=0.
- With IF_ADDR_CHECK_EN, branch_target=0xBFC00102 -> IC_IF_1[0]=1, inst_1=0; int=6'b000100 -> IC_IF_1[1]=1.
